level_outcome_judge: RTL

- Produces the `stageEnded` pulse and `playerWon` flag that the stage state machine consumes.
- Also tracks the level number, the level countdown and the score target.
- Sits between the game logic (score, confirm key, frame strobe) and the stage controller, and reads back the current `stage` to know what to judge.
- Stage encoding: 0 LEVEL, 1 SHOP, 2 WIN_MENU, 3 LOSS_MENU, 4 MAIN_MENU, 5 GAME_END. Values 6–15 are treated as menus.

---
 rtl/level_outcome_judge_if.sv | 37 +++
 rtl/level_outcome_judge.sv | 133 +++++++++++++
 2 files changed

// File: rtl/level_outcome_judge_if.sv
// Signal bundle between the game logic / stage controller and the level outcome judge.
// The judge takes the slave view; whoever drives the game inputs takes the master view.
interface level_outcome_judge_if;
   logic        startOfFrame;
   logic [3:0]  stage;
   logic        confirmKey;
   logic [15:0] score;
   logic        stageEnded;
   logic        playerWon;
   logic [6:0]  timeLeft;
   logic [3:0]  level;
   logic [15:0] target;

   modport master (
      output startOfFrame,
      output stage,
      output confirmKey,
      output score,
      input  stageEnded,
      input  playerWon,
      input  timeLeft,
      input  level,
      input  target
   );

   modport slave (
      input  startOfFrame,
      input  stage,
      input  confirmKey,
      input  score,
      output stageEnded,
      output playerWon,
      output timeLeft,
      output level,
      output target
   );
endinterface

// File: rtl/level_outcome_judge.sv
// Decides when the current stage is over (timer expiry in LEVEL, confirm key elsewhere),
// records the win/loss outcome and keeps the level number, countdown and score target.
module level_outcome_judge #(
   parameter int FRAMES_PER_SEC = 30,
   parameter int LEVEL_SECONDS  = 60,
   parameter int BASE_TARGET    = 650,
   parameter int TARGET_STEP    = 300,
   parameter int MAX_LEVEL      = 9
) (
   input  logic                  clk,
   input  logic                  resetN,
   level_outcome_judge_if.slave  bus
);

   localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAMES_PER_SEC - 1);
   localparam logic [6:0]    TIME_LOAD    = 7'(LEVEL_SECONDS);
   localparam logic [3:0]    LEVEL_MAX    = 4'(MAX_LEVEL);
   localparam logic [15:0]   TARGET_RESET = (BASE_TARGET > 65535) ? 16'hFFFF : 16'(BASE_TARGET);
   localparam logic [3:0]    STAGE_LEVEL     = 4'd0;
   localparam logic [3:0]    STAGE_MAIN_MENU = 4'd4;

   typedef enum logic [1:0] {
      ARMED = 2'd0,
      PULSE = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    prev_stage_q, prev_stage_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic          key_prev_q, key_prev_d;
   logic          player_won_q, player_won_d;
   logic [6:0]    time_left_q, time_left_d;
   logic [3:0]    level_q, level_d;
   logic [15:0]   target_q, target_d;

   logic          entry;
   logic          key_edge;
   logic          score_ok;
   logic [19:0]   target_sum;

   assign entry    = (bus.stage != prev_stage_q);
   assign key_edge = bus.confirmKey & ~key_prev_q;
   assign score_ok = (bus.score >= target_q);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ARMED;
         prev_stage_q <= STAGE_MAIN_MENU;
         frame_cnt_q  <= '0;
         key_prev_q   <= 1'b0;
         player_won_q <= 1'b0;
         time_left_q  <= TIME_LOAD;
         level_q      <= 4'd1;
         target_q     <= TARGET_RESET;
      end else begin
         state_q      <= state_d;
         prev_stage_q <= prev_stage_d;
         frame_cnt_q  <= frame_cnt_d;
         key_prev_q   <= key_prev_d;
         player_won_q <= player_won_d;
         time_left_q  <= time_left_d;
         level_q      <= level_d;
         target_q     <= target_d;
      end
   end

   // Target follows the registered level, so it settles one clock after a level change.
   always_comb begin
      target_sum = 20'(BASE_TARGET) + 20'(level_q - 4'd1) * 20'(TARGET_STEP);
      target_d   = (target_sum > 20'h0FFFF) ? 16'hFFFF : target_sum[15:0];
   end

   always_comb begin
      state_d      = state_q;
      prev_stage_d = bus.stage;
      frame_cnt_d  = frame_cnt_q;
      key_prev_d   = bus.confirmKey;
      player_won_d = player_won_q;
      time_left_d  = time_left_q;
      level_d      = level_q;

      // A stage change takes priority and swallows any frame or key event in the same clock.
      if (entry) begin
         state_d = ARMED;
         if (bus.stage == STAGE_LEVEL) begin
            time_left_d  = TIME_LOAD;
            frame_cnt_d  = '0;
            player_won_d = 1'b0;
         end else if (bus.stage == STAGE_MAIN_MENU) begin
            level_d      = 4'd1;
            player_won_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            ARMED: begin
               if (bus.stage == STAGE_LEVEL) begin
                  if (bus.startOfFrame) begin
                     if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        if (time_left_q != 7'd0) begin
                           time_left_d = time_left_q - 7'd1;
                           if (time_left_q == 7'd1) begin
                              state_d      = PULSE;
                              player_won_d = score_ok;
                              if (score_ok && (level_q < LEVEL_MAX)) begin
                                 level_d = level_q + 4'd1;
                              end
                           end
                        end
                     end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                     end
                  end
               end else if (key_edge) begin
                  state_d = PULSE;
               end
            end
            PULSE:   state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = ARMED;
         endcase
      end
   end

   assign bus.stageEnded = (state_q == PULSE);
   assign bus.playerWon  = player_won_q;
   assign bus.timeLeft   = time_left_q;
   assign bus.level      = level_q;
   assign bus.target     = target_q;

endmodule
